// File: rtl/mux_n_1_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_1_seq_pkg
//  Description : Shared definitions for the sequential N:1 word selector.
//                Holds the walk-direction encoding used on s_dir.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_n_1_seq_pkg;

  // Direction of the index walk across the held bundle.
  typedef enum logic {
    DIR_INC = 1'b0,  // index increments, wrapping N-1 -> 0
    DIR_DEC = 1'b1   // index decrements, wrapping 0 -> N-1
  } dir_e;

endpackage : mux_n_1_seq_pkg
`default_nettype wire

// File: rtl/mux_n_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_1
//  Description : Combinational N:1 word multiplexer, N = 2**LOG2_N.
//                Word i of the bundle occupies i_data[i*WIDTH +: WIDTH].
//  Ports       : i_data  - packed bundle of N words, word 0 at the LSBs
//                i_sel   - index of the word to route to the output
//                o_data  - selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_1 #(
  parameter int WIDTH    = 8,
  parameter int LOG2_N   = 2,
  parameter int IN_WIDTH = (1 << LOG2_N) * WIDTH
) (
  input  logic [IN_WIDTH-1:0] i_data,
  input  logic [LOG2_N-1:0]   i_sel,
  output logic [WIDTH-1:0]    o_data
);

  localparam int N = 1 << LOG2_N;

  logic [WIDTH-1:0] w_words [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign w_words[gi] = i_data[gi*WIDTH +: WIDTH];
  end

  assign o_data = w_words[i_sel];

endmodule : mux_n_1
`default_nettype wire

// File: rtl/mux_n_1_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_1_seq
//  Description : Sequential, handshaked N:1 word selector. Accepts a bundle
//                of N = 2**LOG2_N words with a start index, a beat count and
//                a direction, then emits the selected words one per beat on
//                a registered valid/ready stream, wrapping modulo N.
//  Ports       : clk      - sole clock, rising edge
//                reset    - synchronous reset, active low
//                s_data   - request bundle, word i at s_data[i*WIDTH +: WIDTH]
//                s_sel    - index of the first word emitted
//                s_count  - beats minus one
//                s_dir    - 0 increment, 1 decrement (modulo N)
//                s_valid  - request valid
//                s_ready  - request accepted when s_valid && s_ready
//                m_data   - selected word (registered)
//                m_idx    - index of the word on m_data (registered)
//                m_last   - final beat of the request (registered)
//                m_valid  - output beat valid (registered)
//                m_ready  - beat consumed when m_valid && m_ready
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_1_seq
  import mux_n_1_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOG2_N   = 2,
  parameter int IN_WIDTH = (1 << LOG2_N) * WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic [LOG2_N-1:0]   s_sel,
  input  logic [LOG2_N-1:0]   s_count,
  input  logic                s_dir,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic [LOG2_N-1:0]   m_idx,
  output logic                m_last,
  output logic                m_valid,
  input  logic                m_ready
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [LOG2_N-1:0] IDX_ONE  = LOG2_N'(1);
  localparam logic [LOG2_N-1:0] IDX_ZERO = '0;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e              r_state;
  logic [IN_WIDTH-1:0] r_bundle;
  dir_e                r_dir;
  logic [LOG2_N-1:0]   r_rem;
  logic [LOG2_N-1:0]   r_idx;
  logic [WIDTH-1:0]    r_data;
  logic                r_last;
  logic                r_valid;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  state_e              w_state_nxt;
  logic                w_load_new;
  logic                w_advance;
  logic                w_drop;
  logic                w_xfer;
  logic                w_ready;
  logic                w_accept;
  logic [LOG2_N-1:0]   w_step_idx;
  logic [IN_WIDTH-1:0] w_mux_bundle;
  logic [LOG2_N-1:0]   w_mux_sel;
  logic [WIDTH-1:0]    w_mux_data;

  assign w_xfer = r_valid && m_ready;

  // Ready is freed in the cycle the last beat transfers so that a follow-on
  // request loads its first beat on the same edge (no bubble). Held low while
  // reset is asserted so nothing is accepted during reset.
  assign w_ready  = reset && ((r_state == ST_IDLE) || (w_xfer && r_last));
  assign w_accept = s_valid && w_ready;

  // LOG2_N-bit arithmetic gives the modulo-N wrap for free.
  assign w_step_idx = (r_dir == DIR_DEC) ? (r_idx - IDX_ONE) : (r_idx + IDX_ONE);

  // A single selector serves both cases: on accept it picks the first word
  // straight from the incoming bundle, otherwise the next word from the held
  // bundle. Its output only reaches m_data through a register.
  assign w_mux_bundle = w_load_new ? s_data : r_bundle;
  assign w_mux_sel    = w_load_new ? s_sel  : w_step_idx;

  mux_n_1 #(
    .WIDTH    (WIDTH),
    .LOG2_N   (LOG2_N),
    .IN_WIDTH (IN_WIDTH)
  ) u_mux (
    .i_data (w_mux_bundle),
    .i_sel  (w_mux_sel),
    .o_data (w_mux_data)
  );

  // --------------------------------------------------------------------------
  // FSM: next state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_advance   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load_new  = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // Without a transfer everything holds: valid never drops unconsumed.
        if (w_xfer) begin
          if (!r_last) begin
            w_advance = 1'b1;
          end else if (w_accept) begin
            w_load_new = 1'b1;
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bundle <= '0;
      r_dir    <= DIR_INC;
      r_rem    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_load_new) begin
      r_bundle <= s_data;
      r_dir    <= dir_e'(s_dir);
      r_rem    <= s_count;
      r_idx    <= s_sel;
      r_data   <= w_mux_data;
      r_last   <= (s_count == IDX_ZERO);
      r_valid  <= 1'b1;
    end else if (w_advance) begin
      r_idx    <= w_step_idx;
      r_data   <= w_mux_data;
      r_rem    <= r_rem - IDX_ONE;
      // Remaining is about to become zero: this is the final beat.
      r_last   <= (r_rem == IDX_ONE);
    end else if (w_drop) begin
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_ready = w_ready;
  assign m_data  = r_data;
  assign m_idx   = r_idx;
  assign m_last  = r_last;
  assign m_valid = r_valid;

endmodule : mux_n_1_seq
`default_nettype wire

// File: tb/tb_mux_n_1_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_n_1_seq
//  Description : Directed self-checking bench for mux_n_1_seq (WIDTH=8,
//                LOG2_N=2). Bundle {0a,0b,0c,0d} -> word0=0d .. word3=0a.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_1_seq;

  localparam int WIDTH  = 8;
  localparam int LOG2_N = 2;
  localparam int IN_W   = (1 << LOG2_N) * WIDTH;

  logic            clk;
  logic            reset;
  logic [IN_W-1:0] s_data;
  logic [1:0]      s_sel;
  logic [1:0]      s_count;
  logic            s_dir;
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      m_data;
  logic [1:0]      m_idx;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;

  int n_pass;
  int n_total;

  mux_n_1_seq #(
    .WIDTH  (WIDTH),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_sel   (s_sel),
    .s_count (s_count),
    .s_dir   (s_dir),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] i,
                      input logic l);
    chk({tag, "_valid"}, m_valid, 1'b1);
    chk({tag, "_data"},  m_data,  d);
    chk({tag, "_idx"},   m_idx,   i);
    chk({tag, "_last"},  m_last,  l);
  endtask

  task automatic request(input logic [1:0] sel, input logic [1:0] cnt, input logic dir);
    s_sel   = sel;
    s_count = cnt;
    s_dir   = dir;
    s_valid = 1'b1;
  endtask

  localparam logic [IN_W-1:0] BUNDLE = {8'h0a, 8'h0b, 8'h0c, 8'h0d};

  logic [7:0] exp_d [4];
  logic [1:0] exp_i [4];
  logic       bp    [7];
  int         b;

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    s_data  = BUNDLE;
    s_sel   = '0;
    s_count = '0;
    s_dir   = 1'b0;
    s_valid = 1'b1;   // reset must override a pending request
    m_ready = 1'b1;

    // ---------------- reset ----------------
    tick();
    chk("rst_s_ready", s_ready, 1'b0);
    tick();
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_last",  m_last,  1'b0);
    chk("rst_data",  m_data,  8'h00);
    chk("rst_idx",   m_idx,   2'd0);
    s_valid = 1'b0;
    reset   = 1'b1;
    #1;
    chk("idle_s_ready", s_ready, 1'b1);

    // ---------------- single beat ----------------
    request(2'd0, 2'd0, 1'b0);
    tick();
    s_valid = 1'b0;
    beat("single", 8'h0d, 2'd0, 1'b1);
    tick();
    chk("single_after_valid", m_valid, 1'b0);

    // ---------------- 4 beats incrementing from 2 ----------------
    exp_d = '{8'h0b, 8'h0a, 8'h0d, 8'h0c};
    exp_i = '{2'd2, 2'd3, 2'd0, 2'd1};
    request(2'd2, 2'd3, 1'b0);
    tick();
    s_valid = 1'b0;
    s_data  = '0;   // held bundle must not follow the input
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("inc_b%0d", k), exp_d[k], exp_i[k], k == 3);
      tick();
    end
    chk("inc_after_valid", m_valid, 1'b0);
    s_data = BUNDLE;

    // ---------------- 3 beats decrementing from 1 ----------------
    exp_d = '{8'h0c, 8'h0d, 8'h0a, 8'h00};
    exp_i = '{2'd1, 2'd0, 2'd3, 2'd0};
    request(2'd1, 2'd2, 1'b1);
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("dec_b%0d", k), exp_d[k], exp_i[k], k == 2);
      tick();
    end
    chk("dec_after_valid", m_valid, 1'b0);

    // ---------------- backpressure ----------------
    exp_d = '{8'h0b, 8'h0a, 8'h0d, 8'h0c};
    exp_i = '{2'd2, 2'd3, 2'd0, 2'd1};
    bp    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    request(2'd2, 2'd3, 1'b0);
    tick();
    s_valid = 1'b0;
    b = 0;
    for (int c = 0; c < 7; c++) begin
      m_ready = bp[c];
      #1;
      beat($sformatf("bp_c%0d", c), exp_d[b], exp_i[b], b == 3);
      chk($sformatf("bp_s_ready_c%0d", c), s_ready, (bp[c] && b == 3));
      if (bp[c]) b++;
      tick();
    end
    chk("bp_beats", b, 4);
    chk("bp_after_valid", m_valid, 1'b0);
    m_ready = 1'b1;

    // ---------------- back-to-back ----------------
    request(2'd2, 2'd3, 1'b0);
    tick();
    s_sel   = 2'd3;   // B's fields, s_valid stays high
    s_count = 2'd0;
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("b2b_a%0d", k), exp_d[k], exp_i[k], k == 3);
      chk($sformatf("b2b_s_ready_%0d", k), s_ready, k == 3);
      tick();
    end
    s_valid = 1'b0;
    beat("b2b_b", 8'h0a, 2'd3, 1'b1);
    tick();
    chk("b2b_after_valid", m_valid, 1'b0);

    // ---------------- reset mid-request ----------------
    request(2'd2, 2'd3, 1'b0);
    tick();
    s_valid = 1'b0;
    beat("mid_b0", 8'h0b, 2'd2, 1'b0);
    tick();
    beat("mid_b1", 8'h0a, 2'd3, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_s_ready", s_ready, 1'b0);
    tick();
    chk("mid_valid", m_valid, 1'b0);
    chk("mid_data",  m_data,  8'h00);
    chk("mid_idx",   m_idx,   2'd0);
    chk("mid_last",  m_last,  1'b0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_no_replay_%0d", k), m_valid, 1'b0);
    end

    // ---------------- fresh request after reset ----------------
    request(2'd0, 2'd0, 1'b0);
    tick();
    s_valid = 1'b0;
    beat("fresh", 8'h0d, 2'd0, 1'b1);
    tick();
    chk("fresh_after_valid", m_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux_n_1_seq
`default_nettype wire
